// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU data port: byte-lane RAM with configurable
// wait states, a stall back-pressure output, and a console/halt MMIO window.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        mmio_valid_o,
  output logic [7:0]  mmio_data_o,
  output logic        halt_o
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic                    we_reg;
  logic                    ram_sel_reg;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [1:0]              off_reg;
  logic [3:0]              sel_reg;
  logic [31:0]             wdata_reg;
  logic                    mmio_valid_reg;
  logic [7:0]              mmio_data_reg;
  logic                    halt_reg;
  logic                    data_zero_reg;
  logic [7:0]              lane_q [4];

  logic                    req_ram_sel;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    going_resp;
  logic                    rd_we;
  logic                    rd_ram_sel;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    rd_load;
  logic                    wr_commit;
  logic                    unused_addr_bits;

  assign unused_addr_bits = &{1'b0, addr_i[1:0]};
  assign req_ram_sel      = (addr_i[31:4] != MMIO_BASE[31:4]);
  assign req_idx          = addr_i[ADDR_WIDTH+1:2];

  // The RAM read is issued on the edge that enters RESP; with zero wait
  // states that edge is the accepting one, so address comes straight from the port.
  always_comb begin
    going_resp = 1'b0;
    rd_we      = we_reg;
    rd_ram_sel = ram_sel_reg;
    rd_idx     = idx_reg;
    if (state_reg == S_IDLE) begin
      going_resp = ce_i && (WAIT_CYCLES == 0);
      rd_we      = we_i;
      rd_ram_sel = req_ram_sel;
      rd_idx     = req_idx;
    end else if (state_reg == S_WAIT) begin
      going_resp = ce_i && (cnt_reg == 4'd0);
    end
  end

  assign rd_load   = going_resp && !rd_we && !rst;
  assign wr_commit = (state_reg == S_RESP) && we_reg && ram_sel_reg && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 4'd0;
      we_reg         <= 1'b0;
      ram_sel_reg    <= 1'b0;
      idx_reg        <= '0;
      off_reg        <= 2'd0;
      sel_reg        <= 4'd0;
      wdata_reg      <= 32'd0;
      mmio_valid_reg <= 1'b0;
      mmio_data_reg  <= 8'd0;
      halt_reg       <= 1'b0;
      data_zero_reg  <= 1'b1;
    end else begin
      mmio_valid_reg <= 1'b0;
      if (going_resp && !rd_we) begin
        data_zero_reg <= !rd_ram_sel;
      end
      case (state_reg)
        S_IDLE: begin
          if (ce_i) begin
            we_reg      <= we_i;
            ram_sel_reg <= req_ram_sel;
            idx_reg     <= req_idx;
            off_reg     <= addr_i[3:2];
            sel_reg     <= sel_i;
            wdata_reg   <= data_i;
            if (WAIT_CYCLES == 0) begin
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_WAIT;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!ce_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_RESP: begin
          state_reg <= S_IDLE;
          // MMIO side effects land on the same edge a RAM write would commit.
          if (we_reg && !ram_sel_reg) begin
            if (off_reg == 2'd0 && sel_reg[0]) begin
              mmio_valid_reg <= 1'b1;
              mmio_data_reg  <= wdata_reg[7:0];
            end
            if (off_reg == 2'd1) begin
              halt_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // One byte-wide RAM per lane keeps lane writes independent.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_commit && sel_reg[gi]) begin
          mem[idx_reg] <= wdata_reg[8*gi +: 8];
        end
        if (rd_load) begin
          lane_q[gi] <= mem[rd_idx];
        end
      end
    end
  endgenerate

  assign data_o       = data_zero_reg ? 32'd0 : {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
  assign ready_o      = (state_reg == S_RESP);
  assign stall_o      = ce_i & ~ready_o;
  assign mmio_valid_o = mmio_valid_reg;
  assign mmio_data_o  = mmio_data_reg;
  assign halt_o       = halt_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 3 and 0 wait states)
// driven by directed and random accesses against a word-array memory model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        ce     [3];
  logic        we     [3];
  logic [31:0] addr   [3];
  logic [3:0]  sel    [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        ready  [3];
  logic        stall  [3];
  logic        mval   [3];
  logic [7:0]  mdata  [3];
  logic        halt   [3];

  logic [31:0] model_mem  [3][1024];
  logic [7:0]  model_con  [3];
  logic        model_halt [3];
  logic [31:0] last_rd;

  int checks;
  int failures;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      data_mem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 3 : 0)),
        .MMIO_BASE  (32'h0003_0000)
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce[gi]),
        .we_i        (we[gi]),
        .addr_i      (addr[gi]),
        .sel_i       (sel[gi]),
        .data_i      (wdata[gi]),
        .data_o      (rdata[gi]),
        .ready_o     (ready[gi]),
        .stall_o     (stall[gi]),
        .mmio_valid_o(mval[gi]),
        .mmio_data_o (mdata[gi]),
        .halt_o      (halt[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in an IDLE cycle at a falling edge, ends in the following IDLE cycle.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] v);
    int          n;
    logic        got;
    logic        is_mmio;
    logic [9:0]  idx;
    logic [31:0] exp_rd;
    logic        exp_v;
    is_mmio = (a[31:4] == 28'h0003000);
    idx     = a[11:2];
    exp_rd  = is_mmio ? 32'd0 : model_mem[d][idx];
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = v;
    #1;
    check("stall_accept", stall[d], 1'b1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("mmio_valid_pulse_end", mval[d], 1'b0);
      got = ready[d];
      if (!got) check("stall_wait", stall[d], 1'b1);
    end
    check("latency", n, wait_of(d) + 1);
    check("stall_resp", stall[d], 1'b0);
    last_rd = rdata[d];
    if (!w) check("rdata", rdata[d], exp_rd);
    ce[d] = 1'b0;
    if (w && !is_mmio) begin
      for (int l = 0; l < 4; l++) begin
        if (s[l]) model_mem[d][idx][8*l +: 8] = v[8*l +: 8];
      end
    end
    exp_v = w && is_mmio && (a[3:2] == 2'd0) && s[0];
    if (exp_v) model_con[d] = v[7:0];
    if (w && is_mmio && (a[3:2] == 2'd1)) model_halt[d] = 1'b1;
    @(negedge clk);
    check("mmio_valid", mval[d], exp_v);
    check("mmio_data", mdata[d], model_con[d]);
    check("halt", halt[d], model_halt[d]);
  endtask

  task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] v);
    int pulses;
    pulses = 0;
    ce[d] = 1'b1; we[d] = 1'b1; addr[d] = a; sel[d] = 4'hF; wdata[d] = v;
    repeat (2) begin
      @(negedge clk);
      if (ready[d]) pulses++;
    end
    ce[d] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready[d]) pulses++;
    end
    check("abort_no_ready", pulses, 0);
  endtask

  initial begin
    int          lat [3];
    logic        pending;
    logic [31:0] rnd;
    logic [31:0] a;
    logic [31:0] v;
    logic [3:0]  s;
    logic        w;

    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ce[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; sel[d] = 4'd0; wdata[d] = 32'd0;
      model_con[d] = 8'd0; model_halt[d] = 1'b0; lat[d] = -1;
      for (int i = 0; i < 1024; i++) model_mem[d][i] = 32'd0;
    end

    // Reset with a request already pending.
    #3 rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ce[d] = 1'b1; we[d] = 1'b0; addr[d] = 32'h40; sel[d] = 4'hF;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_data", rdata[d], 32'd0);
      check("reset_flags", {29'd0, ready[d], mval[d], halt[d]}, 32'd0);
      check("reset_mdata", mdata[d], 8'd0);
    end
    rst = 1'b0;
    pending = 1'b1;
    for (int n = 1; n <= 20 && pending; n++) begin
      @(negedge clk);
      pending = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (lat[d] < 0 && ready[d]) begin
          lat[d] = n;
          ce[d]  = 1'b0;
        end
        if (lat[d] < 0) pending = 1'b1;
      end
    end
    for (int d = 0; d < 3; d++) check("reset_release_latency", lat[d], wait_of(d) + 1);
    repeat (2) @(negedge clk);

    // Bring every RAM to a known state.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 1024; i++) access(d, 1'b1, 32'(i) << 2, 4'hF, 32'd0);
    end

    // Full-word write then read, one wait state.
    access(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
    access(0, 1'b0, 32'h40, 4'hF, 32'd0);
    check("deadbeef_literal", last_rd, 32'hDEADBEEF);

    // Byte lanes and an empty-lane write.
    access(0, 1'b1, 32'h100, 4'hF, 32'h11223344);
    access(0, 1'b1, 32'h100, 4'b0101, 32'hAABBCCDD);
    access(0, 1'b0, 32'h100, 4'hF, 32'd0);
    check("lanes_literal", last_rd, 32'h11BB33DD);
    access(0, 1'b1, 32'h100, 4'b0000, 32'hFFFFFFFF);
    access(0, 1'b0, 32'h100, 4'b0000, 32'd0);
    check("sel0_literal", last_rd, 32'h11BB33DD);

    // Abandoned write with three wait states.
    abort_write(1, 32'h80, 32'h12345678);
    access(1, 1'b0, 32'h80, 4'hF, 32'd0);
    check("abort_literal", last_rd, 32'd0);

    // Console, halt, MMIO read.
    access(0, 1'b1, 32'h0003_0000, 4'hF, 32'h00000041);
    check("console_literal", mdata[0], 8'h41);
    access(0, 1'b1, 32'h0003_0004, 4'hF, 32'h00000001);
    access(0, 1'b0, 32'h0003_0000, 4'hF, 32'd0);
    check("mmio_read_literal", last_rd, 32'd0);
    access(0, 1'b0, 32'h40, 4'hF, 32'd0);
    check("halt_sticky", halt[0], 1'b1);

    // Zero wait states and address aliasing.
    access(2, 1'b1, 32'h1004, 4'hF, 32'h5);
    access(2, 1'b0, 32'h0004, 4'hF, 32'd0);
    check("alias_literal", last_rd, 32'h5);

    // Random traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 150; k++) begin
        rnd = $urandom;
        w   = rnd[0];
        s   = rnd[7:4];
        v   = $urandom;
        if ($urandom_range(0, 4) == 0) begin
          a = 32'h0003_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        end else begin
          a = {rnd[31:12], 5'd0, 5'($urandom_range(0, 31)), rnd[9:8]};
          if (a[31:4] == 28'h0003000) a[31] = 1'b1;
        end
        access(d, w, a, s, v);
      end
    end

    // Reset in the middle of a write leaves memory and MMIO untouched.
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h200; sel[1] = 4'hF; wdata[1] = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    ce[1] = 1'b0;
    #1;
    check("midreset_ready", ready[1], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      model_con[d]  = 8'd0;
      model_halt[d] = 1'b0;
    end
    access(1, 1'b0, 32'h200, 4'hF, 32'd0);
    access(0, 1'b0, 32'h40, 4'hF, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
